// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: ALU operations, operand selects and forwarding
// source, plus the storage layout of the EX issue slot.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  typedef enum logic {
    A_RS1,
    A_PC
  } a_sel_t;

  typedef enum logic {
    B_RS2,
    B_IMM
  } b_sel_t;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_MEM,
    FWD_WB
  } fwd_sel_t;

  // All-zero encodes the reset slot: invalid, ADD, A_RS1, B_RS2.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    a_sel_t            a_sel;
    b_sel_t            b_sel;
    alu_op_t           alu_op;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
  } slot_t;

endpackage

// File: rtl/ex_issue_stage_fwd_unit.sv
// Source-register match against the MEM and WB results; MEM is younger and
// wins. x0 never matches.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic       mem_rd_we,
  input  logic [4:0] mem_rd_addr,
  input  logic       wb_rd_we,
  input  logic [4:0] wb_rd_addr,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_NONE;
    if (src_addr != '0) begin
      if (mem_rd_we && (mem_rd_addr == src_addr)) begin
        sel = FWD_MEM;
      end else if (wb_rd_we && (wb_rd_addr == src_addr)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// Single-slot EX issue register with operand selection. Define RISCV_FWD_EN to
// build MEM/WB forwarding; otherwise decode stalls on RAW hazards.
module ex_issue_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  a_sel_t      id_a_sel,
  input  b_sel_t      id_b_sel,
  input  alu_op_t     id_alu_op,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_rd_we,
  input  logic        mem_rd_we,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        wb_rd_we,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_rd_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output alu_op_t     alu_op,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_rd_we
);

  slot_t       slot_q, slot_d;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] rs1_opnd, rs2_opnd;
  logic        hazard_stall;
  logic        capture;

`ifdef RISCV_FWD_EN
  fwd_sel_t rs1_sel, rs2_sel;

  fwd_unit u_fwd_rs1 (
    .src_addr    (slot_q.rs1_addr),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .sel         (rs1_sel)
  );

  fwd_unit u_fwd_rs2 (
    .src_addr    (slot_q.rs2_addr),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .sel         (rs2_sel)
  );

  always_comb begin
    rs1_val = slot_q.rs1_data;
    rs2_val = slot_q.rs2_data;
    case (rs1_sel)
      FWD_MEM: rs1_val = mem_rd_data;
      FWD_WB:  rs1_val = wb_rd_data;
      default: rs1_val = slot_q.rs1_data;
    endcase
    case (rs2_sel)
      FWD_MEM: rs2_val = mem_rd_data;
      FWD_WB:  rs2_val = wb_rd_data;
      default: rs2_val = slot_q.rs2_data;
    endcase
  end

  assign hazard_stall = 1'b0;
`else
  fwd_sel_t id_rs1_sel, id_rs2_sel;
  logic     slot_rs1_hit, slot_rs2_hit;

  // Without forwarding the match logic looks at the decoding instruction's
  // sources, so any in-flight producer holds decode back.
  fwd_unit u_fwd_rs1 (
    .src_addr    (id_rs1_addr),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .sel         (id_rs1_sel)
  );

  fwd_unit u_fwd_rs2 (
    .src_addr    (id_rs2_addr),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .sel         (id_rs2_sel)
  );

  assign rs1_val      = slot_q.rs1_data;
  assign rs2_val      = slot_q.rs2_data;
  assign slot_rs1_hit = slot_q.valid && slot_q.rd_we && (id_rs1_addr != '0) &&
                        (slot_q.rd_addr == id_rs1_addr);
  assign slot_rs2_hit = slot_q.valid && slot_q.rd_we && (id_rs2_addr != '0) &&
                        (slot_q.rd_addr == id_rs2_addr);
  assign hazard_stall = id_valid && (slot_rs1_hit || slot_rs2_hit ||
                        (id_rs1_sel != FWD_NONE) || (id_rs2_sel != FWD_NONE));
`endif

  assign id_ready = !flush && (!slot_q.valid || ex_ready) && !hazard_stall;
  assign capture  = id_valid && id_ready;

  always_comb begin
    slot_d = slot_q;
    // Refresh held sources so a result retiring during a stall is kept.
    if (slot_q.valid && !ex_ready) begin
      slot_d.rs1_data = rs1_val;
      slot_d.rs2_data = rs2_val;
    end
    if (flush) begin
      slot_d.valid = 1'b0;
    end else if (capture) begin
      slot_d.valid    = 1'b1;
      slot_d.pc       = id_pc;
      slot_d.rs1_addr = id_rs1_addr;
      slot_d.rs2_addr = id_rs2_addr;
      slot_d.rs1_data = id_rs1_data;
      slot_d.rs2_data = id_rs2_data;
      slot_d.imm      = id_imm;
      slot_d.a_sel    = id_a_sel;
      slot_d.b_sel    = id_b_sel;
      slot_d.alu_op   = id_alu_op;
      slot_d.rd_addr  = id_rd_addr;
      slot_d.rd_we    = id_rd_we;
    end else if (slot_q.valid && ex_ready) begin
      slot_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rs1_opnd   = (slot_q.rs1_addr == '0) ? '0 : rs1_val;
  assign rs2_opnd   = (slot_q.rs2_addr == '0) ? '0 : rs2_val;
  assign alu_a      = (slot_q.a_sel == A_PC)  ? slot_q.pc  : rs1_opnd;
  assign alu_b      = (slot_q.b_sel == B_IMM) ? slot_q.imm : rs2_opnd;
  assign alu_op     = slot_q.valid ? slot_q.alu_op : ALU_ADD;
  assign ex_valid   = slot_q.valid;
  assign ex_pc      = slot_q.pc;
  assign ex_rd_addr = slot_q.rd_addr;
  assign ex_rd_we   = slot_q.valid && slot_q.rd_we;

endmodule
